decoder_scan_ctrl: RTL
======================

# decoder_scan_ctrl

Upstream sequencer for the 3-to-8 enable decoder: generates the `en` and `sel[2:0]` pair that the decoder expands into one-hot outputs. It steps `sel` through the eight positions with a programmable dwell time and an optional blanking gap, supports continuous run, single-step, up/down direction and ping-pong (bounce) scanning, and flags each end-of-scan with a one-cycle `wrap` pulse. All outputs are registered, so the decoder sees glitch-free inputs.

## Interface
- `DWELL`, default 4: cycles `en` stays high per position; legal range ≥1.
- `BLANK`, default 1: cycles `en` stays low between positions; legal range ≥0.
- `CW`, default 16: width of the internal period counter; must hold max(DWELL, BLANK)−1.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; 1 = scan continuously.
- `step` in 1: pulse; in IDLE, advance exactly one position.
- `dir` in 1: 0 = ascending `sel`, 1 = descending; sampled at each advance.
- `bounce` in 1: 1 = ping-pong at ends; 0 = modulo-8 wrap.
- `en` out 1: decoder enable.
- `sel` out 3: decoder select.
- `wrap` out 1: one-cycle end-of-scan pulse.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, SHOW, GAP. `en`=1 only in SHOW.
- Reset: state IDLE; `sel`=0; `en`=0; `wrap`=0; `busy`=0; counter=0; reverse flag `rev`=0. Reset overrides all other inputs.
- IDLE:
  - `run`=1 → SHOW, counter=0, continuous mode.
  - else `step`=1 → SHOW, single-shot mode.
  - `run` and `step` both high → `run` wins.
  - `sel` is unchanged on entry to SHOW.
- SHOW: counter increments each cycle. At counter=DWELL−1:
  - BLANK>0 → GAP, counter=0.
  - BLANK=0 → advance point.
- GAP: counter increments each cycle; counter=BLANK−1 → advance point.
- Advance point (the last cycle of the position period):
  - Compute next `sel`.
  - Next state is SHOW if in continuous mode and `run`=1; otherwise IDLE.
  - Deasserting `run` mid-period therefore takes effect only at the period boundary: the current position completes and `sel` still advances.
- `step` is ignored when not in IDLE.
- Effective direction `d` = `dir` XOR `rev`. `rev` is forced to 0 on every cycle with `bounce`=0.
- Next `sel` with `bounce`=0: `sel`+1 mod 8 if `d`=0, `sel`−1 mod 8 if `d`=1. A 7→0 or 0→7 transition sets `wrap`.
- Next `sel` with `bounce`=1:
  - `d`=0 and `sel`=7: toggle `rev`, next `sel`=6, set `wrap`.
  - `d`=1 and `sel`=0: toggle `rev`, next `sel`=1, set `wrap`.
  - Otherwise step by ±1, no `wrap`.
- Changing `dir` or `bounce` mid-period has no effect until the next advance point.

## Timing
- `run` sampled high at edge k (in IDLE): `en`=1, `busy`=1 from cycle k+1.
- Position period P = DWELL+BLANK cycles: `en` high DWELL cycles, then low BLANK cycles.
- `sel` and `wrap` update on the edge that ends the advance cycle.
  - The new `sel` appears together with `en` rising (BLANK>0) or with `en` held high (BLANK=0).
  - `wrap`=1 for exactly the first cycle of the new `sel`.
- Single step: `busy` high for exactly P cycles, then IDLE with `sel` advanced by one.
- Reset mid-scan: next cycle `en`=0, `sel`=0, IDLE. With `run` still high, SHOW resumes one cycle after `reset` falls.

## Test plan
- Reset: hold `reset` 2 cycles with `run`=1 → `en`=0, `sel`=0, `wrap`=0, `busy`=0 throughout; `en` rises 1 cycle after release.
- Continuous up (defaults): `run`=1, `dir`=0, `bounce`=0 for 45 cycles.
  - Required: `sel` 0,1,…,7,0, each held 5 cycles with `en` pattern 1,1,1,1,0.
  - Required: `wrap` high only in the first cycle of the second `sel`=0.
- Single step: from IDLE at `sel`=3, pulse `step` → `busy` high 5 cycles (`en` 4 high, 1 low), then `sel`=4, IDLE. A second `step` during `busy` is ignored.
- Bounce: start `sel`=6, `dir`=0, `bounce`=1 → `sel` 6,7,6,5,…,1,0,1 with `wrap` pulses at the 7→6 and 0→1 transitions only.
- Descending wrap and run drop: `dir`=1 from `sel`=0 → 7 with `wrap`. Drop `run` in the 2nd cycle at `sel`=7 → position completes, `sel`=6, IDLE, `en`=0.
- BLANK=0 instance (DWELL=2): `run`=1 → `en` continuously 1, `sel` changes every 2 cycles. Assert `reset` at `sel`=5 → next cycle `en`=0, `sel`=0.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for the 3-to-8 enable decoder: steps sel through eight positions
// with a dwell/blank period, optional ping-pong scanning, and a registered wrap pulse.
module decoder_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int BLANK = 1,
  parameter int CW    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       dir,
  input  logic       bounce,
  output logic       en,
  output logic [2:0] sel,
  output logic       wrap,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          cont, cont_n;
  logic          rev, rev_n;
  logic [2:0]    sel_n, sel_adv;
  logic          wrap_n, wrap_adv, rev_tgl, adv, d;

  // Candidate next position; only consumed on the advance cycle, so mid-period
  // changes of dir/bounce have no visible effect until then.
  always_comb begin
    d        = dir ^ (rev & bounce);
    sel_adv  = d ? (sel - 3'd1) : (sel + 3'd1);
    rev_tgl  = 1'b0;
    wrap_adv = 1'b0;
    if (bounce) begin
      if (!d && sel == 3'd7) begin
        sel_adv  = 3'd6;
        rev_tgl  = 1'b1;
        wrap_adv = 1'b1;
      end else if (d && sel == 3'd0) begin
        sel_adv  = 3'd1;
        rev_tgl  = 1'b1;
        wrap_adv = 1'b1;
      end
    end else begin
      wrap_adv = d ? (sel == 3'd0) : (sel == 3'd7);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cont_n  = cont;
    sel_n   = sel;
    wrap_n  = 1'b0;
    rev_n   = bounce ? rev : 1'b0;
    adv     = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_n = SHOW;
          cnt_n   = '0;
          cont_n  = 1'b1;
        end else if (step) begin
          state_n = SHOW;
          cnt_n   = '0;
          cont_n  = 1'b0;
        end
      end
      SHOW: begin
        if (cnt == DW_LAST) begin
          if (BLANK > 0) begin
            state_n = GAP;
            cnt_n   = '0;
          end else begin
            adv = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == BL_LAST) adv = 1'b1;
        else                cnt_n = cnt + CW'(1);
      end
      default: state_n = IDLE;
    endcase
    // Period boundary: run is only re-checked here, so a dropped run still
    // completes the current position and advances sel.
    if (adv) begin
      sel_n   = sel_adv;
      wrap_n  = wrap_adv;
      cnt_n   = '0;
      state_n = (cont && run) ? SHOW : IDLE;
      if (rev_tgl) rev_n = ~rev;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cont  <= 1'b0;
      rev   <= 1'b0;
      sel   <= 3'd0;
      wrap  <= 1'b0;
      en    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cont  <= cont_n;
      rev   <= rev_n;
      sel   <= sel_n;
      wrap  <= wrap_n;
      en    <= (state_n == SHOW);
      busy  <= (state_n != IDLE);
    end
  end

endmodule
